// File: rtl/cache_miss_fsm.sv
// cache_miss_fsm
//   Data-cache miss controller. One FSM handles read misses, allocating write misses
//   and write-through stores. Write-back, write-allocate and critical-word restart are
//   chosen by parameter.
//
//   state   | meaning
//   --------+----------------------------------------------------------------
//   IDLE    | serve hits; on a miss start the fill (and victim write-back)
//   FILL    | pipeline stalled on the miss, waiting for the critical word / done
//   FILL_BG | critical word already forwarded; fill finishing in background,
//           | read hits to other indices are served
//   INSTALL | one-cycle full-line write from LF into the arrays (+ store merge)
//   WT_WAIT | store held on the write-through port until it is accepted
//
// Ports
//   Clk, Rst            clock (rising edge), synchronous active-high reset
//   En, RW, WordAddress processor access (RW=1 write)
//   Stall               hold pipeline, access must be re-presented
//   C_Miss, C_Dirty     tag-miss and victim-dirty status from the arrays
//   R_Enable, W_Enable  cache read / single-word write of the current access
//   WriteLine, Merge    install line from LF, merge pending store word
//   CrtWord             forward critical word from LF to the pipeline
//   LF_Start/FirstWord/Done  line-fill buffer handshake
//   WB_Start/Done       victim write-back buffer handshake
//   WT_Valid, WT_Ready  write-through store port
//   FillIndex           index of the line under fill
//   Busy                FSM not idle
module cache_miss_fsm #(
    parameter int ADDR_W     = 32,
    parameter int LINE_T     = 11,
    parameter int LINE_B     = 5,
    parameter int WRITE_BACK = 1,
    parameter int WR_ALLOC   = 1,
    parameter int CWF        = 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     En,
    input  logic                     RW,
    input  logic [ADDR_W-1:0]        WordAddress,
    output logic                     Stall,
    input  logic                     C_Miss,
    input  logic                     C_Dirty,
    output logic                     R_Enable,
    output logic                     W_Enable,
    output logic                     WriteLine,
    output logic                     Merge,
    output logic                     CrtWord,
    output logic                     LF_Start,
    input  logic                     LF_FirstWord,
    input  logic                     LF_Done,
    output logic                     WB_Start,
    input  logic                     WB_Done,
    output logic                     WT_Valid,
    input  logic                     WT_Ready,
    output logic [LINE_T-LINE_B:0]   FillIndex,
    output logic                     Busy
);

    localparam int  IDX_W  = LINE_T - LINE_B + 1;
    localparam bit  WB_EN  = (WRITE_BACK != 0);
    localparam bit  WA_EN  = (WR_ALLOC != 0);
    localparam bit  CWF_EN = (CWF != 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        FILL_BG = 3'd2,
        INSTALL = 3'd3,
        WT_WAIT = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              lf_pend_q, lf_pend_d;
    logic              wb_pend_q, wb_pend_d;
    logic              is_wr_q, is_wr_d;
    logic              lf_start_q, lf_start_d;
    logic              wb_start_q, wb_start_d;
    logic [IDX_W-1:0]  fill_index_q, fill_index_d;

    logic [IDX_W-1:0]  acc_index;
    logic              unused_addr;

    assign acc_index   = WordAddress[LINE_T:LINE_B];
    assign unused_addr = ^{WordAddress[ADDR_W-1:LINE_T+1], WordAddress[LINE_B-1:0]};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= IDLE;
            lf_pend_q    <= 1'b0;
            wb_pend_q    <= 1'b0;
            is_wr_q      <= 1'b0;
            lf_start_q   <= 1'b0;
            wb_start_q   <= 1'b0;
            fill_index_q <= '0;
        end else begin
            state_q      <= state_d;
            lf_pend_q    <= lf_pend_d;
            wb_pend_q    <= wb_pend_d;
            is_wr_q      <= is_wr_d;
            lf_start_q   <= lf_start_d;
            wb_start_q   <= wb_start_d;
            fill_index_q <= fill_index_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lf_pend_d    = lf_pend_q;
        wb_pend_d    = wb_pend_q;
        is_wr_d      = is_wr_q;
        fill_index_d = fill_index_q;
        lf_start_d   = 1'b0;
        wb_start_d   = 1'b0;
        Stall        = 1'b0;
        R_Enable     = 1'b0;
        W_Enable     = 1'b0;
        WriteLine    = 1'b0;
        Merge        = 1'b0;
        CrtWord      = 1'b0;
        WT_Valid     = 1'b0;

        case (state_q)
            IDLE: begin
                if (En) begin
                    if (!C_Miss) begin
                        if (!RW) begin
                            R_Enable = 1'b1;
                        end else if (WB_EN) begin
                            W_Enable = 1'b1;
                        end else begin
                            WT_Valid = 1'b1;
                            if (WT_Ready) begin
                                W_Enable = 1'b1;
                            end else begin
                                Stall   = 1'b1;
                                state_d = WT_WAIT;
                            end
                        end
                    end else if (!RW || WA_EN) begin
                        Stall        = 1'b1;
                        state_d      = FILL;
                        fill_index_d = acc_index;
                        is_wr_d      = RW;
                        lf_start_d   = 1'b1;
                        wb_start_d   = WB_EN && C_Dirty;
                        lf_pend_d    = 1'b1;
                        wb_pend_d    = WB_EN && C_Dirty;
                    end else begin
                        // Non-allocating write miss: store goes out the WT port only.
                        WT_Valid = 1'b1;
                        if (!WT_Ready) begin
                            Stall   = 1'b1;
                            state_d = WT_WAIT;
                        end
                    end
                end
            end

            WT_WAIT: begin
                WT_Valid = 1'b1;
                if (WT_Ready) begin
                    W_Enable = En && !C_Miss;
                    state_d  = IDLE;
                end else begin
                    Stall = 1'b1;
                end
            end

            FILL, FILL_BG: begin
                lf_pend_d = lf_pend_q && !LF_Done;
                wb_pend_d = wb_pend_q && !WB_Done;
                if (state_q == FILL) begin
                    Stall = 1'b1;
                    if (LF_FirstWord && !is_wr_q && CWF_EN) begin
                        CrtWord = 1'b1;
                        Stall   = 1'b0;
                        state_d = FILL_BG;
                    end
                end else if (En) begin
                    // Only read hits outside the line being filled can proceed.
                    if (!RW && !C_Miss && (acc_index != fill_index_q)) begin
                        R_Enable = 1'b1;
                    end else begin
                        Stall = 1'b1;
                    end
                end
                if (!lf_pend_d && !wb_pend_d) begin
                    state_d = INSTALL;
                end
            end

            INSTALL: begin
                WriteLine = 1'b1;
                Merge     = is_wr_q;
                Stall     = En;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are forced quiet while reset is held.
        if (Rst) begin
            Stall     = 1'b0;
            R_Enable  = 1'b0;
            W_Enable  = 1'b0;
            WriteLine = 1'b0;
            Merge     = 1'b0;
            CrtWord   = 1'b0;
            WT_Valid  = 1'b0;
        end
    end

    assign LF_Start  = lf_start_q && !Rst;
    assign WB_Start  = wb_start_q && !Rst;
    assign FillIndex = fill_index_q;
    assign Busy      = (state_q != IDLE) && !Rst;

endmodule

// File: tb/tb_cache_miss_fsm.sv
module tb_cache_miss_fsm;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        En = 1'b0, RW = 1'b0;
    logic [31:0] WordAddress = '0;
    logic        C_Miss = 1'b0, C_Dirty = 1'b0;
    logic        LF_FirstWord = 1'b0, LF_Done = 1'b0, WB_Done = 1'b0, WT_Ready = 1'b1;

    logic Stall, R_Enable, W_Enable, WriteLine, Merge, CrtWord;
    logic LF_Start, WB_Start, WT_Valid, Busy;
    logic [6:0] FillIndex;

    logic w_Stall, w_R_Enable, w_W_Enable, w_WriteLine, w_Merge, w_CrtWord;
    logic w_LF_Start, w_WB_Start, w_WT_Valid, w_Busy;
    logic [6:0] w_FillIndex;

    int errors = 0;
    int checks = 0;
    int lf_cnt = 0;
    int wb_cnt = 0;

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (LF_Start) lf_cnt++;
        if (WB_Start) wb_cnt++;
    end

    cache_miss_fsm dut (
        .Clk(Clk), .Rst(Rst), .En(En), .RW(RW), .WordAddress(WordAddress),
        .Stall(Stall), .C_Miss(C_Miss), .C_Dirty(C_Dirty),
        .R_Enable(R_Enable), .W_Enable(W_Enable), .WriteLine(WriteLine), .Merge(Merge),
        .CrtWord(CrtWord), .LF_Start(LF_Start), .LF_FirstWord(LF_FirstWord),
        .LF_Done(LF_Done), .WB_Start(WB_Start), .WB_Done(WB_Done),
        .WT_Valid(WT_Valid), .WT_Ready(WT_Ready), .FillIndex(FillIndex), .Busy(Busy)
    );

    cache_miss_fsm #(.WRITE_BACK(0)) dut_wt (
        .Clk(Clk), .Rst(Rst), .En(En), .RW(RW), .WordAddress(WordAddress),
        .Stall(w_Stall), .C_Miss(C_Miss), .C_Dirty(C_Dirty),
        .R_Enable(w_R_Enable), .W_Enable(w_W_Enable), .WriteLine(w_WriteLine),
        .Merge(w_Merge), .CrtWord(w_CrtWord), .LF_Start(w_LF_Start),
        .LF_FirstWord(LF_FirstWord), .LF_Done(LF_Done), .WB_Start(w_WB_Start),
        .WB_Done(WB_Done), .WT_Valid(w_WT_Valid), .WT_Ready(WT_Ready),
        .FillIndex(w_FillIndex), .Busy(w_Busy)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        En = 1'b0; RW = 1'b0; C_Miss = 1'b0; C_Dirty = 1'b0;
        LF_FirstWord = 1'b0; LF_Done = 1'b0; WB_Done = 1'b0; WT_Ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        Rst = 1'b1;
        tick(); tick();
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        Rst = 1'b1;
        En = 1'b1; RW = 1'b0; WordAddress = 32'h40;
        tick(); #1;
        checks++; if (R_Enable !== 1'b0) begin errors++; $display("FAIL rst_ren_quiet got=%0b exp=0", R_Enable); end
        tick();
        Rst = 1'b0;
        tick(); #1;
        checks++; if (R_Enable !== 1'b1) begin errors++; $display("FAIL rd_hit_ren got=%0b exp=1", R_Enable); end
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL rd_hit_stall got=%0b exp=0", Stall); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rd_hit_busy got=%0b exp=0", Busy); end
        checks++; if (w_R_Enable !== 1'b1) begin errors++; $display("FAIL wt_rd_hit_ren got=%0b exp=1", w_R_Enable); end
        idle_inputs();
        tick();
    endtask

    task automatic test_read_miss_cwf();
        int lf0, wb0;
        lf0 = lf_cnt; wb0 = wb_cnt;
        En = 1'b1; RW = 1'b0; WordAddress = 32'h1A0; C_Miss = 1'b1; C_Dirty = 1'b0;
        #1;
        checks++; if (Stall !== 1'b1 || R_Enable !== 1'b0) begin errors++; $display("FAIL rmiss_k0 stall=%0b ren=%0b exp stall=1 ren=0", Stall, R_Enable); end
        for (int k = 1; k <= 11; k++) begin
            tick();
            LF_FirstWord = (k == 4);
            LF_Done = (k == 9);
            En = (k <= 4);
            #1;
            if (k < 4) begin
                checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL rmiss_stall k=%0d got=%0b exp=1", k, Stall); end
            end
            if (k == 4) begin
                checks++; if (CrtWord !== 1'b1 || Stall !== 1'b0) begin errors++; $display("FAIL rmiss_crt crt=%0b stall=%0b exp crt=1 stall=0", CrtWord, Stall); end
            end
            if (k == 10) begin
                checks++; if (WriteLine !== 1'b1 || Merge !== 1'b0) begin errors++; $display("FAIL rmiss_install wl=%0b merge=%0b exp wl=1 merge=0", WriteLine, Merge); end
            end
            if (k == 11) begin
                checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rmiss_busy_end got=%0b exp=0", Busy); end
            end
        end
        idle_inputs();
        checks++; if (lf_cnt - lf0 != 1) begin errors++; $display("FAIL rmiss_lf_start_cnt got=%0d exp=1", lf_cnt - lf0); end
        checks++; if (wb_cnt - wb0 != 0) begin errors++; $display("FAIL rmiss_wb_start_cnt got=%0d exp=0", wb_cnt - wb0); end
    endtask

    task automatic test_crit_done_same();
        En = 1'b1; RW = 1'b0; WordAddress = 32'h3E0; C_Miss = 1'b1;
        tick();
        #1;
        checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL same_stall got=%0b exp=1", Stall); end
        tick();
        LF_FirstWord = 1'b1; LF_Done = 1'b1;
        #1;
        checks++; if (CrtWord !== 1'b1 || Stall !== 1'b0) begin errors++; $display("FAIL same_crt crt=%0b stall=%0b exp crt=1 stall=0", CrtWord, Stall); end
        tick();
        idle_inputs();
        #1;
        checks++; if (WriteLine !== 1'b1) begin errors++; $display("FAIL same_install got=%0b exp=1", WriteLine); end
        tick(); #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL same_busy_end got=%0b exp=0", Busy); end
    endtask

    task automatic test_dirty_write_miss();
        int lf0, wb0;
        lf0 = lf_cnt; wb0 = wb_cnt;
        En = 1'b1; RW = 1'b1; WordAddress = 32'h2C0; C_Miss = 1'b1; C_Dirty = 1'b1;
        #1;
        checks++; if (Stall !== 1'b1 || W_Enable !== 1'b0) begin errors++; $display("FAIL wmiss_k0 stall=%0b wen=%0b exp stall=1 wen=0", Stall, W_Enable); end
        for (int k = 1; k <= 8; k++) begin
            tick();
            WB_Done = (k == 6);
            LF_Done = (k == 6);
            C_Miss = (k < 8);
            #1;
            if (k < 7) begin
                checks++; if (Stall !== 1'b1 || W_Enable !== 1'b0) begin errors++; $display("FAIL wmiss_hold k=%0d stall=%0b wen=%0b exp stall=1 wen=0", k, Stall, W_Enable); end
            end
            if (k == 7) begin
                checks++; if (WriteLine !== 1'b1 || Merge !== 1'b1 || Stall !== 1'b1) begin errors++; $display("FAIL wmiss_install wl=%0b merge=%0b stall=%0b exp 1 1 1", WriteLine, Merge, Stall); end
            end
            if (k == 8) begin
                checks++; if (W_Enable !== 1'b1 || Stall !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL wmiss_replay wen=%0b stall=%0b busy=%0b exp 1 0 0", W_Enable, Stall, Busy); end
            end
        end
        idle_inputs();
        checks++; if (lf_cnt - lf0 != 1 || wb_cnt - wb0 != 1) begin errors++; $display("FAIL wmiss_start_cnt lf=%0d wb=%0d exp lf=1 wb=1", lf_cnt - lf0, wb_cnt - wb0); end
    endtask

    task automatic test_done_order();
        En = 1'b1; RW = 1'b1; WordAddress = 32'h500; C_Miss = 1'b1; C_Dirty = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            LF_Done = (k == 3);
            WB_Done = (k == 5);
            C_Miss = (k < 7);
            #1;
            if (k == 4 || k == 5) begin
                checks++; if (WriteLine !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL order_wait k=%0d wl=%0b busy=%0b exp wl=0 busy=1", k, WriteLine, Busy); end
            end
            if (k == 6) begin
                checks++; if (WriteLine !== 1'b1) begin errors++; $display("FAIL order_install got=%0b exp=1", WriteLine); end
            end
            if (k == 7) begin
                checks++; if (W_Enable !== 1'b1) begin errors++; $display("FAIL order_replay got=%0b exp=1", W_Enable); end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_hit_under_fill();
        En = 1'b1; RW = 1'b0; WordAddress = 32'hA0; C_Miss = 1'b1; C_Dirty = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            LF_FirstWord = (k == 2);
            LF_Done = (k == 6);
            En = (k <= 5);
            RW = (k == 5);
            C_Miss = (k <= 2);
            WordAddress = (k == 3 || k == 5) ? 32'h60 : 32'hA0;
            #1;
            if (k == 2) begin
                checks++; if (CrtWord !== 1'b1) begin errors++; $display("FAIL huf_crt got=%0b exp=1", CrtWord); end
            end
            if (k == 3) begin
                checks++; if (FillIndex !== 7'd5) begin errors++; $display("FAIL huf_fillindex got=%0d exp=5", FillIndex); end
                checks++; if (R_Enable !== 1'b1 || Stall !== 1'b0) begin errors++; $display("FAIL huf_other_idx ren=%0b stall=%0b exp ren=1 stall=0", R_Enable, Stall); end
            end
            if (k == 4) begin
                checks++; if (R_Enable !== 1'b0 || Stall !== 1'b1) begin errors++; $display("FAIL huf_same_idx ren=%0b stall=%0b exp ren=0 stall=1", R_Enable, Stall); end
            end
            if (k == 5) begin
                checks++; if (W_Enable !== 1'b0 || Stall !== 1'b1) begin errors++; $display("FAIL huf_write wen=%0b stall=%0b exp wen=0 stall=1", W_Enable, Stall); end
            end
            if (k == 7) begin
                checks++; if (WriteLine !== 1'b1) begin errors++; $display("FAIL huf_install got=%0b exp=1", WriteLine); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_fill();
        int lf0;
        lf0 = lf_cnt;
        En = 1'b1; RW = 1'b0; WordAddress = 32'h40; C_Miss = 1'b1;
        tick(); #1;
        checks++; if (Busy !== 1'b1 || LF_Start !== 1'b1) begin errors++; $display("FAIL rstfill_pre busy=%0b lfs=%0b exp 1 1", Busy, LF_Start); end
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        idle_inputs();
        #1;
        checks++; if (Busy !== 1'b0 || Stall !== 1'b0 || CrtWord !== 1'b0 || LF_Start !== 1'b0 || WB_Start !== 1'b0 || WriteLine !== 1'b0)
            begin errors++; $display("FAIL rstfill_quiet busy=%0b stall=%0b crt=%0b lfs=%0b wbs=%0b wl=%0b exp all 0", Busy, Stall, CrtWord, LF_Start, WB_Start, WriteLine); end
        tick();
        LF_FirstWord = 1'b1; LF_Done = 1'b1;
        #1;
        checks++; if (CrtWord !== 1'b0) begin errors++; $display("FAIL rstfill_stray_crt got=%0b exp=0", CrtWord); end
        tick();
        idle_inputs();
        #1;
        checks++; if (WriteLine !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL rstfill_stray_done wl=%0b busy=%0b exp 0 0", WriteLine, Busy); end
        tick();
        checks++; if (lf_cnt - lf0 != 1) begin errors++; $display("FAIL rstfill_lf_cnt got=%0d exp=1", lf_cnt - lf0); end
    endtask

    task automatic test_write_through();
        int stall_cyc, wen_cnt;
        stall_cyc = 0; wen_cnt = 0;
        do_reset();
        En = 1'b1; RW = 1'b1; WordAddress = 32'h80; C_Miss = 1'b0; WT_Ready = 1'b0;
        #1;
        checks++; if (W_Enable !== 1'b1 || Stall !== 1'b0) begin errors++; $display("FAIL wb_write_hit wen=%0b stall=%0b exp 1 0", W_Enable, Stall); end
        checks++; if (w_WT_Valid !== 1'b1) begin errors++; $display("FAIL wt_valid got=%0b exp=1", w_WT_Valid); end
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) begin
                tick();
                WT_Ready = (k == 3);
                #1;
            end
            if (w_Stall === 1'b1) stall_cyc++;
            if (w_W_Enable === 1'b1) wen_cnt++;
            if (k == 3) begin
                checks++; if (w_W_Enable !== 1'b1 || w_Stall !== 1'b0) begin errors++; $display("FAIL wt_release wen=%0b stall=%0b exp 1 0", w_W_Enable, w_Stall); end
            end
        end
        tick();
        idle_inputs();
        #1;
        checks++; if (w_Busy !== 1'b0 || w_WT_Valid !== 1'b0) begin errors++; $display("FAIL wt_idle busy=%0b wtv=%0b exp 0 0", w_Busy, w_WT_Valid); end
        checks++; if (stall_cyc != 3) begin errors++; $display("FAIL wt_stall_cycles got=%0d exp=3", stall_cyc); end
        checks++; if (wen_cnt != 1) begin errors++; $display("FAIL wt_wen_count got=%0d exp=1", wen_cnt); end
    endtask

    initial begin
        test_reset();
        test_read_miss_cwf();
        test_crit_done_same();
        test_dirty_write_miss();
        test_done_order();
        test_hit_under_fill();
        test_reset_mid_fill();
        test_write_through();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
